huffman_ctrl: RTL and testbench

Frame-level controller for the Huffman tree builder. Accepts a stream of decimal symbols (0–9), builds the 10-entry frequency histogram, resets and launches the tree builder, and waits for completion. Reports done, degenerate, or error per frame. Sits between the symbol source and the tree builder, and owns the builder's start and reset lines.

---
 rtl/huffman_pkg.sv | 16 +
 rtl/huffman_hist.sv | 46 ++++
 rtl/huffman_ctrl.sv | 108 ++++++++++
 tb/tb_huffman_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared constants and FSM state encoding for the Huffman frame controller.
package huffman_pkg;
    localparam int         NSYM      = 10;
    localparam logic [8:0] EXHAUSTED = 9'h100;
    localparam logic [4:0] TREE_DONE = 5'h1f;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        COUNT = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        FIN   = 3'd5,
        ERR   = 3'd6
    } state_t;
endpackage

// File: rtl/huffman_hist.sv
// Symbol histogram: saturating bins, distinct-bin popcount and Num_bus encoder.
module huffman_hist
    import huffman_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [3:0]        i_sym,
    output logic [3:0]        o_distinct,
    output logic              o_new_bin,
    output logic [9*NSYM-1:0] o_num_bus
);
    logic [NSYM-1:0] w_hit;
    logic [NSYM-1:0] w_nz;

    for (genvar k = 0; k < NSYM; k++) begin : g_bin
        logic [CNT_W-1:0] r_cnt;

        assign w_hit[k] = i_inc && (i_sym == 4'(k));
        assign w_nz[k]  = (r_cnt != '0);

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                r_cnt <= '0;
            else if (i_clr)
                r_cnt <= '0;
            else if (w_hit[k] && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end

        // An empty bin is the builder's "exhausted" marker, not a zero weight
        assign o_num_bus[9*k +: 9] = w_nz[k] ? 9'(r_cnt) : EXHAUSTED;
    end

    always_comb begin
        o_distinct = '0;
        for (int k = 0; k < NSYM; k++)
            o_distinct = o_distinct + 4'(w_nz[k]);
    end

    // Symbol being accepted now lands in a still-empty bin
    assign o_new_bin = |(w_hit & ~w_nz);
endmodule

// File: rtl/huffman_ctrl.sv
// Frame controller: histograms a symbol frame, launches the tree builder and
// reports done / degenerate / timeout per frame.
module huffman_ctrl
    import huffman_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = 16
) (
    input  logic              Clk_in,
    input  logic              Rst,
    input  logic              Sym_valid,
    output logic              Sym_ready,
    input  logic [3:0]        Sym_data,
    input  logic              Sym_last,
    output logic [9*NSYM-1:0] Num_bus,
    output logic              Tree_n_Rst,
    output logic              Start_tree,
    input  logic [4:0]        Tree_m1,
    output logic              Busy,
    output logic              Done,
    output logic              Degen,
    output logic              Err,
    output logic              Bad_sym,
    output logic [LEN_W-1:0]  Frame_len
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           r_state, w_nxt;
    logic [TW-1:0]    r_tmo;
    logic [LEN_W-1:0] r_len;
    logic             r_bad, r_start, r_busy, r_done, r_degen, r_err, r_tree_n_rst;
    logic             w_hs, w_new_bin;
    logic [3:0]       w_distinct;

    assign Sym_ready = (r_state == COUNT);
    assign w_hs      = Sym_valid && Sym_ready;

    huffman_hist #(.CNT_W(CNT_W)) u_hist (
        .i_clk      (Clk_in),
        .i_rst      (Rst),
        .i_clr      (r_state == CLEAR),
        .i_inc      (w_hs),
        .i_sym      (Sym_data),
        .o_distinct (w_distinct),
        .o_new_bin  (w_new_bin),
        .o_num_bus  (Num_bus)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:  if (Sym_valid) w_nxt = CLEAR;
            CLEAR: w_nxt = COUNT;
            // The last symbol is not yet in the bins, so fold it in here
            COUNT: if (w_hs && Sym_last)
                       w_nxt = ((w_distinct + 4'(w_new_bin)) >= 4'd2) ? START : FIN;
            START: w_nxt = WAIT;
            WAIT:  if (Tree_m1 == TREE_DONE)            w_nxt = FIN;
                   else if (r_tmo == TW'(TIMEOUT - 1)) w_nxt = ERR;
            FIN:   w_nxt = IDLE;
            ERR:   w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_degen      <= 1'b0;
            r_err        <= 1'b0;
            r_tree_n_rst <= 1'b0;
            r_tmo        <= '0;
            r_len        <= '0;
            r_bad        <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_start      <= (w_nxt == START);
            r_busy       <= (w_nxt != IDLE);
            r_done       <= (w_nxt == FIN);
            r_degen      <= (r_state == COUNT) && (w_nxt == FIN);
            r_err        <= (w_nxt == ERR);
            r_tree_n_rst <= (w_nxt != CLEAR);
            r_tmo        <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
            if (r_state == CLEAR) begin
                r_len <= '0;
                r_bad <= 1'b0;
            end else if (w_hs) begin
                if (r_len != '1)
                    r_len <= r_len + 1'b1;
                if (Sym_data > 4'd9)
                    r_bad <= 1'b1;
            end
        end
    end

    assign Start_tree = r_start;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Degen      = r_degen;
    assign Err        = r_err;
    assign Tree_n_Rst = r_tree_n_rst;
    assign Bad_sym    = r_bad;
    assign Frame_len  = r_len;
endmodule

// File: tb/tb_huffman_ctrl.sv
// Scoreboard bench for huffman_ctrl with a delay-programmable tree-builder stub.
module tb_huffman_ctrl;
    import huffman_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int NEVER   = 100000;

    logic        Clk_in = 1'b0;
    logic        Rst = 1'b1;
    logic        Sym_valid = 1'b0;
    logic        Sym_last = 1'b0;
    logic [3:0]  Sym_data = '0;
    logic [4:0]  Tree_m1 = '0;
    logic        Sym_ready, Tree_n_Rst, Start_tree, Busy, Done, Degen, Err, Bad_sym;
    logic [89:0] Num_bus;
    logic [15:0] Frame_len;

    huffman_ctrl #(.CNT_W(8), .TIMEOUT(TIMEOUT), .LEN_W(16)) dut (
        .Clk_in(Clk_in), .Rst(Rst), .Sym_valid(Sym_valid), .Sym_ready(Sym_ready),
        .Sym_data(Sym_data), .Sym_last(Sym_last), .Num_bus(Num_bus),
        .Tree_n_Rst(Tree_n_Rst), .Start_tree(Start_tree), .Tree_m1(Tree_m1),
        .Busy(Busy), .Done(Done), .Degen(Degen), .Err(Err),
        .Bad_sym(Bad_sym), .Frame_len(Frame_len)
    );

    always #5 Clk_in = ~Clk_in;

    typedef struct {
        bit          err;
        bit          degen;
        int          len;
        bit          bad;
        logic [89:0] num;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          vecs = 0, errs = 0, cyc = 0;
    int          stub_d = 1, scnt = -1;
    logic        prev_st = 1'b0;
    logic [89:0] exh;

    always @(posedge Clk_in) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Builder stub: raises m1=1f stub_d cycles after the START cycle
    always @(negedge Clk_in) begin
        if (!Tree_n_Rst) begin
            Tree_m1 = '0;
            scnt    = -1;
        end else if (Start_tree) begin
            scnt = stub_d;
        end else if (scnt > 0) begin
            scnt--;
            if (scnt == 0) Tree_m1 = TREE_DONE;
        end
    end

    // Monitor: every Done/Err pulse consumes one scoreboard entry
    always @(negedge Clk_in) begin
        if (!Rst) begin
            if (Start_tree) chk("start_width", prev_st, 1'b0);
            if (Degen && !Done) chk("degen_without_done", Degen, 1'b0);
            if (Done || Err) begin
                if (sb.size() == 0) chk("spurious_done_err", {Done, Err}, 2'b00);
                else begin
                    me = sb.pop_front();
                    chk("done",        Done,      !me.err);
                    chk("err",         Err,       me.err);
                    chk("degen",       Degen,     me.degen);
                    chk("pulse_cycle", cyc,       me.cyc);
                    chk("frame_len",   Frame_len, me.len);
                    chk("bad_sym",     Bad_sym,   me.bad);
                    chk("num_bus",     Num_bus,   me.num);
                end
            end
        end
        prev_st = Start_tree;
    end

    task automatic rst_check(input string tag);
        chk({tag, "_ready"},      Sym_ready,  1'b0);
        chk({tag, "_start"},      Start_tree, 1'b0);
        chk({tag, "_busy"},       Busy,       1'b0);
        chk({tag, "_done"},       {Done, Degen, Err}, 3'b000);
        chk({tag, "_bad"},        Bad_sym,    1'b0);
        chk({tag, "_len"},        Frame_len,  16'd0);
        chk({tag, "_tree_nrst"},  Tree_n_Rst, 1'b0);
        chk({tag, "_num_bus"},    Num_bus,    exh);
    endtask

    task automatic send_frame(input int syms[$], input int d);
        int   h[NSYM];
        int   len, nz, f, guard, k;
        bit   bad;
        exp_t e;
        len = 0; bad = 0; k = 0; guard = 0;
        for (int i = 0; i < NSYM; i++) h[i] = 0;
        for (int i = 0; i < 500 && Busy; i++) @(negedge Clk_in);
        chk("idle_before_frame", Busy, 1'b0);
        stub_d = d;
        @(negedge Clk_in);
        f = cyc;
        while (k < syms.size()) begin
            Sym_valid = 1'b1;
            Sym_data  = 4'(syms[k]);
            Sym_last  = (k == syms.size() - 1);
            if (Sym_ready) begin
                if (k == 0) chk("accept_latency", cyc - f, 2);
                len++;
                if (syms[k] > 9) bad = 1; else h[syms[k]]++;
                if (Sym_last) begin
                    nz = 0;
                    for (int i = 0; i < NSYM; i++) begin
                        if (h[i] > 0) nz++;
                        e.num[9*i +: 9] = (h[i] == 0) ? 9'h100 : 9'((h[i] > 255) ? 255 : h[i]);
                    end
                    e.len   = len;
                    e.bad   = bad;
                    e.degen = (nz < 2);
                    e.err   = !e.degen && (d > TIMEOUT);
                    if (e.degen)          e.cyc = cyc + 1;
                    else if (d <= TIMEOUT) e.cyc = cyc + 2 + d;
                    else                  e.cyc = cyc + TIMEOUT + 2;
                    sb.push_back(e);
                end
                k++;
            end else if (++guard > 50) begin
                chk("sym_ready_timeout", Sym_ready, 1'b1);
                break;
            end
            @(negedge Clk_in);
        end
        Sym_valid = 1'b0;
        Sym_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() > 0; i++) @(negedge Clk_in);
        if (sb.size() > 0) begin
            chk("frame_never_completed", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int q[$];
        int n;
        for (int i = 0; i < NSYM; i++) exh[9*i +: 9] = EXHAUSTED;

        repeat (3) @(negedge Clk_in);
        rst_check("por");
        Rst = 1'b0;
        @(negedge Clk_in);
        chk("tree_nrst_release", Tree_n_Rst, 1'b1);

        q = '{3, 3, 5, 7};   send_frame(q, 11);          drain();
        q.delete(); repeat (300) q.push_back(2); q.push_back(4);
        send_frame(q, 5);    drain();
        q = '{6, 6, 6};      send_frame(q, 5);           drain();
        q = '{1, 12, 0};     send_frame(q, 3);           drain();
        q = '{0, 1};         send_frame(q, NEVER);       drain();
        repeat (2) @(negedge Clk_in);
        chk("busy_after_err", Busy, 1'b0);
        q = '{4, 8};         send_frame(q, TIMEOUT);     drain();
        q = '{4, 8, 8};      send_frame(q, TIMEOUT + 1); drain();
        q = '{9};            send_frame(q, 1);           drain();
        q = '{15, 15};       send_frame(q, 1);           drain();

        // Reset while counting
        for (int i = 0; i < 200 && Busy; i++) @(negedge Clk_in);
        Sym_valid = 1'b1; Sym_data = 4'd3; Sym_last = 1'b0;
        repeat (6) @(negedge Clk_in);
        Rst = 1'b1;
        #1 rst_check("rst_count");
        Sym_valid = 1'b0;
        @(negedge Clk_in);
        Rst = 1'b0;

        // Reset while waiting on the builder
        q = '{2, 5};         send_frame(q, NEVER);
        repeat (5) @(negedge Clk_in);
        Rst = 1'b1;
        sb.delete();
        #1 rst_check("rst_wait");
        @(negedge Clk_in);
        Rst = 1'b0;
        repeat (TIMEOUT + 10) @(negedge Clk_in);
        q = '{7, 7, 1};      send_frame(q, 4);           drain();

        for (int f = 0; f < 25; f++) begin
            q.delete();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++)
                q.push_back(($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 9));
            send_frame(q, $urandom_range(1, TIMEOUT + 2));
            drain();
        end

        repeat (3) @(negedge Clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
